network_sdiv_16s_16s_16_seq: RTL

- Sequential signed 16/16 divider; the inverse operator of the network's 16s x 16s -> 16 multiplier.
- Used by the normalisation and rescale stages of the CAE datapath, where a product must be divided back by a runtime scale.
- Radix-2 restoring algorithm on magnitudes, one quotient bit per clock, then a sign-fix cycle.
- Valid/ready handshake on both input and output. One operation in flight at a time.

---
 rtl/network_sdiv_16s_16s_16_seq_pkg.sv | 29 ++
 rtl/network_sdiv_16s_16s_16_seq_if.sv | 24 ++
 rtl/network_sdiv_16s_16s_16_seq_step.sv | 29 ++
 rtl/network_sdiv_16s_16s_16_seq.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/network_sdiv_16s_16s_16_seq_pkg.sv
// Shared constants, state encoding and magnitude helper for the sequential
// signed divider.
package network_div_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int CNT_W      = $clog2(DATA_WIDTH);

  localparam logic [DATA_WIDTH-1:0] QMAX = 16'h7FFF;
  localparam logic [DATA_WIDTH-1:0] QMIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // One extra bit so that |-32768| is exact.
  function automatic logic [DATA_WIDTH:0] mag_ext(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH:0] ext;
    ext = {v[DATA_WIDTH-1], v};
    if (v[DATA_WIDTH-1]) begin
      mag_ext = -ext;
    end else begin
      mag_ext = ext;
    end
  endfunction

endpackage

// File: rtl/network_sdiv_16s_16s_16_seq_if.sv
// Operand/result handshake bundle for the sequential signed divider.
interface network_sdiv_16s_16s_16_seq_if;

  logic                                  in_valid;
  logic                                  in_ready;
  logic [network_div_pkg::DATA_WIDTH-1:0] din0;
  logic [network_div_pkg::DATA_WIDTH-1:0] din1;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [network_div_pkg::DATA_WIDTH-1:0] dout;
  logic [network_div_pkg::DATA_WIDTH-1:0] rem;
  logic                                  dbz;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, rem, dbz
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, rem, dbz
  );

endinterface

// File: rtl/network_sdiv_16s_16s_16_seq_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference only when it does not borrow.
module network_sdiv_step #(
  parameter int W = 16
) (
  input  logic [W:0] rem_in,
  input  logic       bit_in,
  input  logic [W:0] divisor,
  output logic [W:0] rem_out,
  output logic       q_bit
);

  logic [W+1:0] shifted_s;
  logic [W+1:0] diff_s;

  // Partial remainder stays below the divisor, so the shifted value never
  // overflows W+1 bits and diff_s[W+1] is a clean borrow.
  always_comb begin
    shifted_s = {rem_in, bit_in};
    diff_s    = shifted_s - {1'b0, divisor};
    q_bit     = ~diff_s[W+1];
    if (q_bit) begin
      rem_out = diff_s[W:0];
    end else begin
      rem_out = shifted_s[W:0];
    end
  end

endmodule

// File: rtl/network_sdiv_16s_16s_16_seq.sv
// Sequential signed 16/16 divider: magnitudes in, one quotient bit per clock,
// a sign-fix cycle, then the result is held until the consumer takes it.
module network_sdiv_16s_16s_16_seq
  import network_div_pkg::*;
(
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  network_sdiv_16s_16s_16_seq_if.slave    bus
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  div_state_t        state_r, state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [W-1:0]      dvd_r;
  logic [W:0]        dvs_r;
  logic [W:0]        part_r;
  logic              sign_q_r, sign_r_r, dbz_pend_r;
  logic              in_ready_r, out_valid_r, dbz_r;
  logic [W-1:0]      dout_r, rem_r;

  logic              accept_s, div_zero_s;
  logic [W:0]        mag0_s, mag1_s, step_rem_s;
  logic              step_q_s;

  assign accept_s   = (state_r == IDLE) && bus.in_valid;
  assign div_zero_s = (bus.din1 == {W{1'b0}});
  assign mag0_s     = mag_ext(bus.din0);
  assign mag1_s     = mag_ext(bus.din1);

  network_sdiv_step #(.W(W)) u_step (
    .rem_in  (part_r),
    .bit_in  (dvd_r[W-1]),
    .divisor (dvs_r),
    .rem_out (step_rem_s),
    .q_bit   (step_q_s)
  );

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = div_zero_s ? FIX : CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == LAST) begin
          state_next_s = FIX;
        end else begin
          state_next_s = CALC;
        end
      end
      FIX: state_next_s = DONE;
      DONE: begin
        if (bus.out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register and handshake flags, decoded from the next state.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
    end
  end

  // Operand capture, iteration datapath and sign fix-up of the results.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_r      <= {CNT_W{1'b0}};
      dvd_r      <= {W{1'b0}};
      dvs_r      <= {(W+1){1'b0}};
      part_r     <= {(W+1){1'b0}};
      sign_q_r   <= 1'b0;
      sign_r_r   <= 1'b0;
      dbz_pend_r <= 1'b0;
      dbz_r      <= 1'b0;
      dout_r     <= {W{1'b0}};
      rem_r      <= {W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            dvd_r      <= mag0_s[W-1:0];
            dvs_r      <= mag1_s;
            // On divide-by-zero the dividend goes straight out as remainder.
            part_r     <= div_zero_s ? mag0_s : {(W+1){1'b0}};
            sign_q_r   <= bus.din0[W-1] ^ bus.din1[W-1];
            sign_r_r   <= bus.din0[W-1];
            dbz_pend_r <= div_zero_s;
            dbz_r      <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
          end
        end
        CALC: begin
          part_r <= step_rem_s;
          dvd_r  <= {dvd_r[W-2:0], step_q_s};
          cnt_r  <= cnt_r + 1'b1;
        end
        FIX: begin
          if (dbz_pend_r) begin
            dout_r <= sign_r_r ? QMIN : QMAX;
            dbz_r  <= 1'b1;
          end else begin
            dout_r <= sign_q_r ? -dvd_r : dvd_r;
            dbz_r  <= 1'b0;
          end
          rem_r <= sign_r_r ? -part_r[W-1:0] : part_r[W-1:0];
        end
        DONE: begin
          dbz_r <= dbz_r;
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.dout      = dout_r;
  assign bus.rem       = rem_r;
  assign bus.dbz       = dbz_r;

endmodule
